// File: rtl/poly_seq_audio_engine.sv
// Polyphonic square-wave step sequencer: a shared step/gate sequencer drives
// VOICES oscillators, mixed to a level count and a 1-bit sigma-delta pin.
// Pattern memory lives outside; notes for step_idx come back on note_in.

// One oscillator voice: latches its half-period at step start, toggles its
// level every hp synth ticks, stays silent for hp == 0.
module poly_seq_voice #(
    parameter int HP_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            tick,
    input  logic [HP_W-1:0] note,
    output logic            lvl
);
    localparam logic [HP_W-1:0] HP_ONE = HP_W'(1);

    logic [HP_W-1:0] hp, cnt;

    // Note latch has priority over the tick so each step starts at phase 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            hp  <= '0;
            cnt <= '0;
            lvl <= 1'b0;
        end else if (load) begin
            hp  <= note;
            cnt <= '0;
            lvl <= 1'b0;
        end else if (tick) begin
            if (hp == '0) begin
                lvl <= 1'b0;
            end else if (cnt == hp - HP_ONE) begin
                cnt <= '0;
                lvl <= ~lvl;
            end else begin
                cnt <= cnt + HP_ONE;
            end
        end
    end
endmodule

module poly_seq_audio_engine #(
    parameter int VOICES    = 2,
    parameter int HP_W      = 7,
    parameter int STEP_W    = 7,
    parameter int SYNTH_DIV = 1024,
    parameter int FRAME_DIV = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    input  logic [STEP_W-1:0]            loop_end,
    input  logic [4:0]                   step_len,
    input  logic [4:0]                   gate_len,
    input  logic [VOICES-1:0]            voice_mask,
    input  logic [VOICES*HP_W-1:0]       note_in,
    output logic [STEP_W-1:0]            step_idx,
    output logic                         step_pulse,
    output logic [$clog2(VOICES+1)-1:0]  mix,
    output logic                         audio
);
    localparam int MIX_W = $clog2(VOICES+1);
    localparam int ACC_W = MIX_W + 1;
    localparam int PS_W  = $clog2(SYNTH_DIV);
    localparam int FR_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [PS_W-1:0]              presc;
    logic [FR_W-1:0]              frame_cnt;
    logic                         synth_tick, frame_tick, osc_tick;
    logic [4:0]                   sub, step_last;
    logic                         adv, load_pending, gate;
    logic [VOICES-1:0][HP_W-1:0]  notes;
    logic [VOICES-1:0]            lvl, vout;
    logic [MIX_W-1:0]             pop;
    logic [ACC_W-1:0]             acc, sd_sum;

    assign synth_tick = (presc == PS_W'(SYNTH_DIV-1));
    assign frame_tick = synth_tick && (frame_cnt == FR_W'(FRAME_DIV-1));
    assign osc_tick   = synth_tick & run;

    // Free-running timebase: prescaler and frame counter ignore run so a
    // pause resumes on the same tick grid.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            frame_cnt <= '0;
        end else begin
            presc <= synth_tick ? '0 : presc + PS_W'(1);
            if (synth_tick)
                frame_cnt <= frame_tick ? '0 : frame_cnt + FR_W'(1);
        end
    end

    // step_len 0 behaves as 1; >= also recovers if step_len shrinks below sub.
    assign step_last = (step_len == 5'd0) ? 5'd0 : step_len - 5'd1;
    assign adv       = frame_tick & run & (sub >= step_last);
    assign gate      = (sub < gate_len);

    // Step sequencer; the note latch request trails every advance by one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub          <= '0;
            step_idx     <= '0;
            step_pulse   <= 1'b0;
            load_pending <= 1'b1;
        end else begin
            step_pulse   <= adv;
            load_pending <= adv;
            if (adv) begin
                sub      <= '0;
                step_idx <= (step_idx >= loop_end) ? '0 : step_idx + STEP_W'(1);
            end else if (frame_tick && run) begin
                sub <= sub + 5'd1;
            end
        end
    end

    assign notes = note_in;

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        poly_seq_voice #(.HP_W(HP_W)) u_voice (
            .clk  (clk),
            .rst  (rst),
            .load (load_pending),
            .tick (osc_tick),
            .note (notes[v]),
            .lvl  (lvl[v])
        );
        assign vout[v] = lvl[v] & gate & voice_mask[v] & run;
    end

    // Count of sounding voices.
    always_comb begin
        pop = '0;
        for (int v = 0; v < VOICES; v++)
            pop = pop + MIX_W'(vout[v]);
    end

    assign sd_sum = acc + ACC_W'(mix);

    // Registered mix and first-order sigma-delta; acc stays in 0..VOICES-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            mix   <= '0;
            acc   <= '0;
            audio <= 1'b0;
        end else begin
            mix <= pop;
            if (sd_sum >= ACC_W'(VOICES)) begin
                audio <= 1'b1;
                acc   <= sd_sum - ACC_W'(VOICES);
            end else begin
                audio <= 1'b0;
                acc   <= sd_sum;
            end
        end
    end
endmodule

// File: tb/tb_poly_seq_audio_engine.sv
// Scoreboard bench: stimulus pushes hand-derived per-cycle samples and step
// pulses into queues; a negedge monitor pops and compares.
module tb_poly_seq_audio_engine;
    localparam int VOICES = 2, HP_W = 7, STEP_W = 7, SYNTH_DIV = 4, FRAME_DIV = 2;
    localparam int MIX_W = $clog2(VOICES+1);

    logic                   clk = 1'b0, rst = 1'b1, run = 1'b1;
    logic [STEP_W-1:0]      loop_end = 7'd127;
    logic [4:0]             step_len = 5'd4, gate_len = 5'd2;
    logic [VOICES-1:0]      voice_mask = 2'b11;
    logic [VOICES*HP_W-1:0] note_in = '0;
    logic [STEP_W-1:0]      step_idx;
    logic                   step_pulse;
    logic [MIX_W-1:0]       mix;
    logic                   audio;

    poly_seq_audio_engine #(.VOICES(VOICES), .HP_W(HP_W), .STEP_W(STEP_W),
                            .SYNTH_DIV(SYNTH_DIV), .FRAME_DIV(FRAME_DIV)) dut (
        .clk(clk), .rst(rst), .run(run), .loop_end(loop_end), .step_len(step_len),
        .gate_len(gate_len), .voice_mask(voice_mask), .note_in(note_in),
        .step_idx(step_idx), .step_pulse(step_pulse), .mix(mix), .audio(audio)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int mix; int audio; int step; } smp_t;
    typedef struct { int cyc; int step; } pls_t;
    smp_t sq[$];
    pls_t pq[$];
    int n_tests = 0, n_fail = 0;

    // Per-step table for steps 0..6 (voice0 always hp=3)
    int t_v1[7]   = '{0, 0, 3, 0, 3, 3, 3};
    int t_gate[7] = '{2, 2, 2, 7, 7, 0, 7};
    int t_mask[7] = '{3, 3, 3, 3, 3, 3, 1};
    int t_m[7]    = '{1, 1, 2, 1, 2, 0, 1};
    int t_hi[7]   = '{16, 16, 16, 24, 24, 0, 24};

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, c, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int c);
        n_tests++;
        n_fail++;
        $display("FAIL %s cyc=%0d", name, c);
    endtask

    // Monitor: compares every queued sample at its cycle and every step pulse.
    always @(negedge clk) begin : mon
        smp_t s;
        pls_t p;
        while (sq.size() > 0 && sq[0].cyc < cyc) begin
            fail_now("sample_missed", sq[0].cyc);
            void'(sq.pop_front());
        end
        if (sq.size() > 0 && sq[0].cyc == cyc) begin
            s = sq.pop_front();
            chk("mix", cyc, 32'(mix), s.mix);
            chk("audio", cyc, 32'(audio), s.audio);
            chk("step_idx", cyc, 32'(step_idx), s.step);
        end
        if (step_pulse === 1'b1) begin
            if (pq.size() == 0) fail_now("pulse_unexpected", cyc);
            else begin
                p = pq.pop_front();
                chk("pulse_cyc", cyc, cyc, p.cyc);
                chk("pulse_idx", cyc, 32'(step_idx), p.step);
            end
        end else if (pq.size() > 0 && pq[0].cyc <= cyc) begin
            fail_now("pulse_missing", pq[0].cyc);
            void'(pq.pop_front());
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_notes(input int v0, input int v1);
        note_in[0 +: HP_W]    = HP_W'(v0);
        note_in[HP_W +: HP_W] = HP_W'(v1);
    endtask

    task automatic push_pulse(input int c, input int st);
        pls_t p;
        p.cyc = c;
        p.step = st;
        pq.push_back(p);
    endtask

    // Step of 32 clks, both voices hp=3 latched at offset 1: level high after
    // offsets 12..23, so mix=m at offsets 13..hi. m=2 saturates the modulator
    // (audio 1 at 14..hi+1); m=1 gives 0,1,0,1 from offset 14 (1 on odd 15..hi+1).
    task automatic push_step(input int base, input int st, input int m, input int hi, input int n);
        smp_t s;
        for (int o = 0; o < n; o++) begin
            s.cyc  = base + o;
            s.step = st;
            s.mix  = (o >= 13 && o <= hi) ? m : 0;
            if (m == 2)      s.audio = (o >= 14 && o <= hi + 1) ? 1 : 0;
            else if (m == 1) s.audio = (o >= 15 && o <= hi + 1 && (o % 2) == 1) ? 1 : 0;
            else             s.audio = 0;
            sq.push_back(s);
        end
    endtask

    initial begin : stim
        int b, p, q;
        smp_t s;
        set_notes(3, 0);
        @(negedge clk);
        // Last reset edge is the next posedge; step 0 starts there.
        b = cyc + 1;
        push_step(b, 0, 1, 16, 32);
        @(negedge clk);
        rst = 1'b0;

        // Steps 1..6: pitch, gate, mix levels, mask
        for (int n = 1; n < 7; n++) begin
            wait_cyc(b + 32*n - 8);
            set_notes(3, t_v1[n]);
            gate_len   = 5'(t_gate[n]);
            voice_mask = 2'(t_mask[n]);
            push_step(b + 32*n, n, t_m[n], t_hi[n], 32);
            push_pulse(b + 32*n, n);
        end

        // Loop wrap: step 6 >= loop_end=2 wraps to 0, then 0,1,2,0,1,2
        wait_cyc(b + 224 - 8);
        gate_len = 5'd0;
        loop_end = 7'd2;
        push_pulse(b + 224, 0);
        push_pulse(b + 256, 1);
        push_pulse(b + 288, 2);
        push_pulse(b + 320, 0);
        push_pulse(b + 352, 1);
        push_pulse(b + 384, 2);
        wait_cyc(b + 384 + 16);
        loop_end = 7'd0;
        push_pulse(b + 416, 0);
        push_pulse(b + 448, 0);

        // Pause for 32 clks in the middle of the high half-cycle
        p = b + 480;
        wait_cyc(p - 8);
        loop_end   = 7'd127;
        gate_len   = 5'd7;
        voice_mask = 2'b11;
        set_notes(3, 0);
        push_pulse(p, 1);
        for (int o = 0; o < 64; o++) begin
            s.cyc  = p + o;
            s.step = 1;
            s.mix  = ((o >= 13 && o <= 18) || (o >= 51 && o <= 56)) ? 1 : 0;
            s.audio = (o == 15 || o == 17 || o == 19 || o == 53 || o == 55 || o == 57) ? 1 : 0;
            sq.push_back(s);
        end
        push_pulse(p + 64, 2);
        wait_cyc(p + 18);
        run = 1'b0;
        wait_cyc(p + 50);
        run = 1'b1;

        // Reset while audio is high; new notes must be latched for step 0
        q = p + 64;
        wait_cyc(q - 8);
        push_step(q, 2, 1, 24, 16);
        push_step(q + 16, 0, 2, 24, 32);
        push_step(q + 48, 1, 2, 24, 32);
        push_pulse(q + 48, 1);
        push_pulse(q + 80, 2);
        wait_cyc(q + 15);
        rst = 1'b1;
        set_notes(3, 3);
        @(negedge clk);
        rst = 1'b0;

        wait_cyc(q + 90);
        if (sq.size() != 0) fail_now("samples_left", cyc);
        if (pq.size() != 0) fail_now("pulses_left", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
